// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter that shares one 4-digit 7-segment driver among SRC_NUM sources.
// Optional time-sliced rotation; display outputs are registered from the pre-edge grant.
module seg_disp_arbiter #(
    parameter int SRC_NUM     = 4,
    parameter int HOLD_WIDTH  = 20,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rotate,
    input  logic [SRC_NUM-1:0]      req,
    input  logic [4*SRC_NUM-1:0]    src_en,
    input  logic [16*SRC_NUM-1:0]   src_data,
    input  logic [4*SRC_NUM-1:0]    src_dot,
    output logic [SRC_NUM-1:0]      grant,
    output logic [2:0]              grant_idx,
    output logic [3:0]              disp_en,
    output logic [15:0]             disp_data,
    output logic [3:0]              disp_dot
);

    // state | meaning
    // IDLE  | no source owns the display, grant all-zero
    // OWN   | exactly one grant bit set, slice counter running or frozen
    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [HOLD_WIDTH-1:0] RELOAD = HOLD_WIDTH'(HOLD_CYCLES - 1);

    state_t                 state;
    logic [2:0]             ptr;
    logic [HOLD_WIDTH-1:0]  cnt;

    logic [SRC_NUM-1:0]     cand;
    logic [SRC_NUM-1:0]     next_onehot;
    logic                   found;
    logic [2:0]             next_idx;
    logic [2:0]             next_ptr;
    logic                   owner_req;
    logic                   take;
    logic                   drop;
    logic [3:0]             sel_en;
    logic [15:0]            sel_data;
    logic [3:0]             sel_dot;

    always_comb begin
        int j;
        j           = 0;
        // Masking with grant excludes the current owner; in IDLE grant is zero.
        cand        = req & ~grant;
        found       = 1'b0;
        next_idx    = 3'd0;
        // Walk from lowest priority to highest so the first hit in search order wins.
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= SRC_NUM) j = j - SRC_NUM;
            if (cand[j]) begin
                found    = 1'b1;
                next_idx = 3'(j);
            end
        end
        next_onehot = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            next_onehot[i] = (int'(next_idx) == i);
        end
        next_ptr  = (int'(next_idx) == SRC_NUM - 1) ? 3'd0 : next_idx + 3'd1;
        owner_req = |(req & grant);
        take      = found && ((state == IDLE) || !owner_req || ((cnt == '0) && rotate));
        drop      = (state == OWN) && !owner_req && !found;

        sel_en   = '0;
        sel_data = '0;
        sel_dot  = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (int'(grant_idx) == i) begin
                sel_en   = src_en[4*i +: 4];
                sel_data = src_data[16*i +: 16];
                sel_dot  = src_dot[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= '0;
            grant     <= '0;
            grant_idx <= 3'd0;
            disp_en   <= 4'd0;
            disp_data <= 16'd0;
            disp_dot  <= 4'd0;
        end else begin
            if (state == OWN) begin
                disp_en   <= sel_en;
                disp_data <= sel_data;
                disp_dot  <= sel_dot;
            end else begin
                disp_en   <= 4'd0;
                disp_data <= 16'd0;
                disp_dot  <= 4'd0;
            end

            if (take) begin
                state     <= OWN;
                grant     <= next_onehot;
                grant_idx <= next_idx;
                ptr       <= next_ptr;
                cnt       <= RELOAD;
            end else if (drop) begin
                state     <= IDLE;
                grant     <= '0;
                grant_idx <= 3'd0;
            end else if ((state == OWN) && owner_req) begin
                // Counter freezes while rotate is low; a lone owner simply renews its slice.
                if (cnt != '0) begin
                    if (rotate) cnt <= cnt - HOLD_WIDTH'(1);
                end else if (rotate) begin
                    cnt <= RELOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Bench for seg_disp_arbiter: two instances (slice 4 and slice 1) share stimulus and are
// checked every cycle against an owner/pointer/slice-age model, plus literal directed checks.
module tb_seg_disp_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rotate;
    logic [3:0]  req;
    logic [15:0] src_en;
    logic [63:0] src_data;
    logic [15:0] src_dot;

    logic [3:0]  grant_a, grant_b;
    logic [2:0]  idx_a, idx_b;
    logic [3:0]  en_a, en_b, dot_a, dot_b;
    logic [15:0] data_a, data_b;

    int total = 0;
    int bad   = 0;

    int          hold[2] = '{4, 1};
    int          m_owner[2];
    int          m_ptr[2];
    int          m_used[2];
    logic [3:0]  m_en[2];
    logic [15:0] m_data[2];
    logic [3:0]  m_dot[2];

    always #5 clk = ~clk;

    seg_disp_arbiter #(.SRC_NUM(4), .HOLD_WIDTH(3), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .rotate(rotate), .req(req),
        .src_en(src_en), .src_data(src_data), .src_dot(src_dot),
        .grant(grant_a), .grant_idx(idx_a),
        .disp_en(en_a), .disp_data(data_a), .disp_dot(dot_a));

    seg_disp_arbiter #(.SRC_NUM(4), .HOLD_WIDTH(20), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .rotate(rotate), .req(req),
        .src_en(src_en), .src_data(src_data), .src_dot(src_dot),
        .grant(grant_b), .grant_idx(idx_b),
        .disp_en(en_b), .disp_data(data_b), .disp_dot(dot_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_ptr[m]   = 0;
            m_used[m]  = 0;
            m_en[m]    = 4'd0;
            m_data[m]  = 16'd0;
            m_dot[m]   = 4'd0;
        end
    endfunction

    function automatic int pick(input int m, input int excl);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr[m] + i) % 4;
            if (req[k] && k != excl) return k;
        end
        return -1;
    endfunction

    function automatic void give(input int m, input int k);
        m_owner[m] = k;
        m_ptr[m]   = (k + 1) % 4;
        m_used[m]  = 0;
    endfunction

    function automatic void model_step(input int m);
        int k;
        int o;
        o = m_owner[m];
        if (o >= 0) begin
            m_en[m]   = src_en[4*o +: 4];
            m_data[m] = src_data[16*o +: 16];
            m_dot[m]  = src_dot[4*o +: 4];
        end else begin
            m_en[m] = 4'd0; m_data[m] = 16'd0; m_dot[m] = 4'd0;
        end
        if (o < 0) begin
            k = pick(m, -1);
            if (k >= 0) give(m, k);
        end else if (!req[o]) begin
            k = pick(m, o);
            if (k >= 0) give(m, k);
            else m_owner[m] = -1;
        end else if (m_used[m] < hold[m] - 1) begin
            if (rotate) m_used[m]++;
        end else if (rotate) begin
            k = pick(m, o);
            if (k >= 0) give(m, k);
            else m_used[m] = 0;
        end
    endfunction

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            logic [3:0]  g, e, d;
            logic [2:0]  gi;
            logic [15:0] dd;
            logic [3:0]  eg;
            g  = (m == 0) ? grant_a : grant_b;
            gi = (m == 0) ? idx_a   : idx_b;
            e  = (m == 0) ? en_a    : en_b;
            d  = (m == 0) ? dot_a   : dot_b;
            dd = (m == 0) ? data_a  : data_b;
            eg = (m_owner[m] >= 0) ? 4'(1 << m_owner[m]) : 4'd0;
            chk($sformatf("model_grant[%0d]", m), 64'(g), 64'(eg));
            chk($sformatf("model_idx[%0d]", m), 64'(gi), 64'((m_owner[m] >= 0) ? m_owner[m] : 0));
            chk($sformatf("model_en[%0d]", m), 64'(e), 64'(m_en[m]));
            chk($sformatf("model_data[%0d]", m), 64'(dd), 64'(m_data[m]));
            chk($sformatf("model_dot[%0d]", m), 64'(d), 64'(m_dot[m]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("reset_grant", 64'(grant_a), 64'd0);
        chk("reset_disp_en", 64'(en_a), 64'd0);
        compare_all();
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rotate = 1'b0; req = 4'd0;
        src_en = 16'd0; src_data = 64'd0; src_dot = 16'd0;
        model_reset();
        @(negedge clk);
        do_reset();

        // single request from source 2
        src_en = 16'h0F00; src_data = 64'h0000_1234_0000_0000; src_dot = 16'h0500;
        req = 4'b0100;
        cycle();
        chk("t1_grant", 64'(grant_a), 64'h4);
        chk("t1_idx", 64'(idx_a), 64'd2);
        chk("t1_data_latency", 64'(data_a), 64'd0);
        cycle();
        chk("t1_data", 64'(data_a), 64'h1234);
        chk("t1_en", 64'(en_a), 64'hF);

        // hold mode, release hand-off with no idle gap
        do_reset();
        rotate = 1'b0; src_en = 16'hFFFF; req = 4'b0011;
        cycle();
        chk("t2_first", 64'(grant_a), 64'h1);
        for (int i = 0; i < 6; i++) cycle();
        chk("t2_held", 64'(grant_a), 64'h1);
        req = 4'b0010;
        cycle();
        chk("t2_handoff", 64'(grant_a), 64'h2);
        req = 4'b0000;
        cycle();
        chk("t2_idle", 64'(grant_a), 64'h0);
        cycle();
        chk("t2_blank", 64'(en_a), 64'h0);

        // rotation with slice of 4 among 0,1,3
        do_reset();
        rotate = 1'b1; req = 4'b1011;
        for (int c = 1; c <= 24; c++) begin
            int seq[3] = '{0, 1, 3};
            cycle();
            chk("t3_rotate", 64'(grant_a), 64'(1 << seq[((c - 1) / 4) % 3]));
        end

        // lone requester keeps the display
        do_reset();
        src_data = 64'hBEEF_0000_0000_0000; req = 4'b1000;
        cycle();
        for (int c = 0; c < 12; c++) begin
            cycle();
            chk("t4_grant", 64'(grant_a), 64'h8);
            chk("t4_data", 64'(data_a), 64'hBEEF);
        end

        // async reset mid-slice
        do_reset();
        src_data = 64'h0000_0000_5A5A_0000; req = 4'b0010;
        for (int c = 0; c < 3; c++) cycle();
        chk("t5_own", 64'(grant_a), 64'h2);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_grant", 64'(grant_a), 64'h0);
        chk("t5_rst_en", 64'(en_a), 64'h0);
        chk("t5_rst_data", 64'(data_a), 64'h0);
        model_reset();
        cycle();
        req = 4'b0110;
        rst = 1'b1;
        cycle();
        chk("t5_restart", 64'(grant_a), 64'h2);

        // slice of 1: advance every cycle, display lags by one
        do_reset();
        src_data = 64'h3333_2222_1111_0000; req = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            chk("t6_grant", 64'(grant_b), 64'(1 << ((c - 1) % 4)));
            if (c >= 2) chk("t6_data", 64'(data_b), 64'(16'h1111 * ((c - 2) % 4)));
        end

        // randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 19) == 0) rotate = ~rotate;
            if ($urandom_range(0, 2) == 0) begin
                src_en   = 16'($urandom);
                src_data = {$urandom, $urandom};
                src_dot  = 16'($urandom);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
